// File: rtl/axi_burst_feeder.sv
// Burst feeder: buffers write data in a show-ahead FIFO and sequences one AXI
// read or write burst at a time, presenting address/attributes and beat data.
module axi_burst_feeder #(
    parameter int size  = 4,
    parameter int depth = 16
) (
    input  logic                aclk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_wr,
    input  logic [size*8-1:0]   cmd_addr,
    input  logic [5:0]          cmd_len,
    input  logic [8:0]          cmd_size,
    input  logic [1:0]          cmd_typ,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [size*8-1:0]   wd_data,
    input  logic                beat_ack,
    input  logic                burst_done,
    output logic                transfer,
    output logic [size*8-1:0]   wadd,
    output logic [size*8-1:0]   radd,
    output logic [8:0]          bsize,
    output logic [5:0]          blen,
    output logic [1:0]          btyp,
    output logic [size*8-1:0]   datain,
    output logic                dlast,
    output logic                busy
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, WFILL, WBURST, RBURST, WDONE} state_t;

    state_t              state, state_nx;
    logic                alive;
    logic [size*8-1:0]   mem [depth];
    logic [AW-1:0]       wptr, rptr;
    logic [CW-1:0]       count;
    logic [5:0]          beat;
    logic                full, empty, push, pop, accept, beat_adv;
    int                  need;

    assign full     = (count == CW'(depth));
    assign empty    = (count == '0);
    // Handshakes stay low through reset and rise on the first edge after it.
    assign wd_ready  = alive & ~full;
    assign cmd_ready = alive & (state == IDLE);
    assign push      = wd_valid & wd_ready;
    assign accept    = cmd_valid & cmd_ready;
    assign pop       = beat_ack & (state == WBURST) & ~empty;
    assign beat_adv  = pop | (beat_ack & (state == RBURST));
    assign dlast     = ((state == WBURST) || (state == RBURST)) && (beat == blen);
    assign datain    = (state == WBURST) ? mem[rptr] : '0;
    assign busy      = (state != IDLE);

    // Bursts longer than the FIFO start once it is full and stream the rest.
    assign need = (int'(blen) + 1 > depth) ? depth : int'(blen) + 1;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = cmd_wr ? WFILL : RBURST;
            WFILL:   if (int'(count) + int'(push) >= need) state_nx = WBURST;
            WBURST:  if (pop && (beat == blen)) state_nx = WDONE;
            RBURST:  if (burst_done) state_nx = IDLE;
            WDONE:   if (burst_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wptr] <= wd_data;
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            alive    <= 1'b0;
            transfer <= 1'b0;
            wadd     <= '0;
            radd     <= '0;
            bsize    <= '0;
            blen     <= '0;
            btyp     <= '0;
            beat     <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            alive    <= 1'b1;
            transfer <= (state_nx == WBURST) || (state_nx == RBURST) || (state_nx == WDONE);
            if (accept) begin
                bsize <= cmd_size;
                blen  <= cmd_len;
                btyp  <= cmd_typ;
                beat  <= '0;
                if (cmd_wr) wadd <= cmd_addr;
                else        radd <= cmd_addr;
            end else if (beat_adv) begin
                beat <= beat + 6'd1;
            end
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A fully buffered burst must never pop an empty FIFO.
    assert property (@(posedge aclk) disable iff (reset)
        !((state == WBURST) && beat_ack && empty && (int'(blen) < depth)));

endmodule

// File: tb/tb_axi_burst_feeder.sv
// Directed bench for axi_burst_feeder: one task per scenario, inline checks.
module tb_axi_burst_feeder;
    localparam int SIZE  = 4;
    localparam int DEPTH = 16;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [5:0]  cmd_len = '0;
    logic [8:0]  cmd_size = 9'd4;
    logic [1:0]  cmd_typ = 2'd1;
    logic        wd_valid = 1'b0, wd_ready;
    logic [31:0] wd_data = '0;
    logic        beat_ack = 1'b0, burst_done = 1'b0;
    logic        transfer, dlast, busy;
    logic [31:0] wadd, radd, datain;
    logic [8:0]  bsize;
    logic [5:0]  blen;
    logic [1:0]  btyp;

    int tests = 0;
    int fails = 0;

    axi_burst_feeder #(.size(SIZE), .depth(DEPTH)) dut (
        .aclk(aclk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_typ(cmd_typ),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .beat_ack(beat_ack), .burst_done(burst_done),
        .transfer(transfer), .wadd(wadd), .radd(radd),
        .bsize(bsize), .blen(blen), .btyp(btyp),
        .datain(datain), .dlast(dlast), .busy(busy)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        wd_valid = 1'b1;
        wd_data  = d;
        tick();
        wd_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [5:0] len);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [136:0] outs;
        repeat (2) tick();
        outs = {cmd_ready, wd_ready, busy, transfer, dlast, wadd, radd, datain, bsize, blen, btyp};
        tests++;
        if (outs !== '0) begin
            fails++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({cmd_ready, wd_ready} !== 2'b00) begin
            fails++; $display("FAIL ready_before_edge: got %b expected 00", {cmd_ready, wd_ready});
        end
        tick();
        tests++;
        if ({cmd_ready, wd_ready, busy} !== 3'b110) begin
            fails++; $display("FAIL ready_after_edge: got %b expected 110", {cmd_ready, wd_ready, busy});
        end
    endtask

    task automatic test_write_burst();
        for (int i = 0; i < 4; i++) push_word(32'hA0 + i);
        send_cmd(1'b1, 32'h100, 6'd3);
        tests++;
        if ({busy, transfer, cmd_ready} !== 3'b100) begin
            fails++; $display("FAIL wr_wfill: got %b expected 100", {busy, transfer, cmd_ready});
        end
        tick();
        tests++;
        if ({transfer, wadd, blen, bsize, btyp} !== {1'b1, 32'h100, 6'd3, 9'd4, 2'd1}) begin
            fails++; $display("FAIL wr_attrs: got %b %h %0d %0d %0d expected 1 100 3 4 1",
                              transfer, wadd, blen, bsize, btyp);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({datain, dlast} !== {32'hA0 + i, (i == 3)}) begin
                fails++; $display("FAIL wr_beat%0d: got %h/%b expected %h/%b",
                                  i, datain, dlast, 32'hA0 + i, (i == 3));
            end
            beat_ack = 1'b1;
            tick();
        end
        beat_ack = 1'b0;
        tests++;
        if ({busy, transfer, dlast} !== 3'b110) begin
            fails++; $display("FAIL wr_wdone: got %b expected 110", {busy, transfer, dlast});
        end
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        tests++;
        if ({busy, transfer, cmd_ready} !== 3'b001) begin
            fails++; $display("FAIL wr_idle: got %b expected 001", {busy, transfer, cmd_ready});
        end
    endtask

    task automatic test_read_burst();
        send_cmd(1'b0, 32'h200, 6'd7);
        tests++;
        if ({transfer, radd, wadd, blen, datain} !== {1'b1, 32'h200, 32'h100, 6'd7, 32'h0}) begin
            fails++; $display("FAIL rd_attrs: got %b %h %h %0d %h expected 1 200 100 7 0",
                              transfer, radd, wadd, blen, datain);
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if ({dlast, cmd_ready} !== {(i == 7), 1'b0}) begin
                fails++; $display("FAIL rd_beat%0d: got dlast/cmd_ready %b expected %b0",
                                  i, {dlast, cmd_ready}, (i == 7));
            end
            beat_ack = 1'b1;
            tick();
        end
        beat_ack = 1'b0;
        tests++;
        if ({busy, cmd_ready} !== 2'b10) begin
            fails++; $display("FAIL rd_wait_done: got %b expected 10", {busy, cmd_ready});
        end
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        tests++;
        if ({busy, transfer, cmd_ready} !== 3'b001) begin
            fails++; $display("FAIL rd_idle: got %b expected 001", {busy, transfer, cmd_ready});
        end
    endtask

    task automatic test_wfill_stall();
        send_cmd(1'b1, 32'h180, 6'd2);
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (transfer !== 1'b0) begin
                fails++; $display("FAIL wfill_hold%0d: got %b expected 0", k, transfer);
            end
            push_word(32'hC0 + k);
            tests++;
            if (transfer !== (k == 2)) begin
                fails++; $display("FAIL wfill_push%0d: got %b expected %b", k, transfer, (k == 2));
            end
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({datain, dlast} !== {32'hC0 + i, (i == 2)}) begin
                fails++; $display("FAIL wfill_beat%0d: got %h/%b expected %h/%b",
                                  i, datain, dlast, 32'hC0 + i, (i == 2));
            end
            beat_ack = 1'b1;
            tick();
        end
        beat_ack = 1'b0;
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < DEPTH; i++) push_word(32'hD0 + i);
        tests++;
        if (wd_ready !== 1'b0) begin
            fails++; $display("FAIL full_wd_ready: got %b expected 0", wd_ready);
        end
        send_cmd(1'b1, 32'h300, 6'd15);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            tests++;
            if ({datain, dlast} !== {32'hD0 + i, (i == 15)}) begin
                fails++; $display("FAIL full_beat%0d: got %h/%b expected %h/%b",
                                  i, datain, dlast, 32'hD0 + i, (i == 15));
            end
            beat_ack = 1'b1;
            wd_valid = (i < 2);
            wd_data  = (i == 0) ? 32'hBAD : 32'hE0;
            tick();
            if (i == 0) begin
                tests++;
                if (wd_ready !== 1'b1) begin
                    fails++; $display("FAIL full_pop_ready: got %b expected 1", wd_ready);
                end
            end
        end
        beat_ack = 1'b0;
        wd_valid = 1'b0;
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        // Only the push made alongside a pop should remain buffered.
        send_cmd(1'b1, 32'h380, 6'd0);
        tick();
        tests++;
        if ({transfer, datain, dlast} !== {1'b1, 32'hE0, 1'b1}) begin
            fails++; $display("FAIL full_leftover: got %b %h %b expected 1 e0 1", transfer, datain, dlast);
        end
        beat_ack = 1'b1;
        tick();
        beat_ack = 1'b0;
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
    endtask

    task automatic test_reset_midburst();
        logic [136:0] outs;
        for (int i = 0; i < 4; i++) push_word(32'h51 + i);
        send_cmd(1'b1, 32'h400, 6'd3);
        tick();
        beat_ack = 1'b1;
        tick();
        tests++;
        if (datain !== 32'h52) begin
            fails++; $display("FAIL mid_second_beat: got %h expected 52", datain);
        end
        #2 reset = 1'b1;
        #1;
        outs = {cmd_ready, wd_ready, busy, transfer, dlast, wadd, radd, datain, bsize, blen, btyp};
        tests++;
        if (outs !== '0) begin
            fails++; $display("FAIL mid_async_reset: got %h expected 0", outs);
        end
        beat_ack = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        push_word(32'h77);
        send_cmd(1'b1, 32'h440, 6'd0);
        tick();
        tests++;
        if ({transfer, datain, dlast} !== {1'b1, 32'h77, 1'b1}) begin
            fails++; $display("FAIL mid_fresh_write: got %b %h %b expected 1 77 1", transfer, datain, dlast);
        end
        beat_ack = 1'b1;
        tick();
        beat_ack = 1'b0;
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL mid_fresh_idle: got %b expected 0", busy);
        end
    endtask

    task automatic test_idle_ignore();
        push_word(32'h99);
        beat_ack = 1'b1;
        burst_done = 1'b1;
        tick();
        beat_ack = 1'b0;
        burst_done = 1'b0;
        tests++;
        if ({busy, transfer, cmd_ready} !== 3'b001) begin
            fails++; $display("FAIL idle_pulse_state: got %b expected 001", {busy, transfer, cmd_ready});
        end
        send_cmd(1'b1, 32'h500, 6'd0);
        tick();
        tests++;
        if ({transfer, datain} !== {1'b1, 32'h99}) begin
            fails++; $display("FAIL idle_no_pop: got %b %h expected 1 99", transfer, datain);
        end
        beat_ack = 1'b1;
        tick();
        beat_ack = 1'b0;
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wfill_stall();
        test_fifo_full();
        test_idle_ignore();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
